// File: rtl/ld_mon_pkg.sv
// Shared types and constants for the laser-driver I2C monitor sequencer.
// Optional watchdog is enabled in the top by defining LD_MON_TIMEOUT_EN.
package ld_mon_pkg;

   localparam int BYTE_W = 8;

   localparam logic [BYTE_W-1:0] DEV_DAQ = 8'h02;
   localparam logic [BYTE_W-1:0] DEV_TRG = 8'h04;

   typedef enum logic [3:0] {
      S_IDLE,
      S_WR_DEV,
      S_WR_NB,
      S_WR_ADDR,
      S_START,
      S_WAIT_DONE,
      S_GAP,
      S_RD,
      S_UPDATE,
      S_ABORT
   } state_t;

   // Byte-count in the high nibble, read flag in bit 3.
   function automatic logic [BYTE_W-1:0] nb_byte(input int unsigned n);
      logic [31:0] v;
      v = n;
      return {v[3:0], 1'b1, 3'b000};
   endfunction

endpackage

// File: rtl/ld_mon_host_mux.sv
// Selects JTAG host or sequencer drive of the I2C interface controls.
// Host wins only while the sequencer is idle and the host asks for the path.
import ld_mon_pkg::*;

module ld_mon_host_mux (
   input  logic              i_busy,
   input  logic              i_host_own,
   input  logic [BYTE_W-1:0] i_host_data,
   input  logic              i_host_we,
   input  logic              i_host_rdena,
   input  logic              i_host_start,
   input  logic              i_host_reset,
   input  logic [BYTE_W-1:0] i_seq_data,
   input  logic              i_seq_we,
   input  logic              i_seq_rdena,
   input  logic              i_seq_start,
   input  logic              i_seq_reset,
   output logic [BYTE_W-1:0] o_data,
   output logic              o_we,
   output logic              o_rdena,
   output logic              o_start,
   output logic              o_reset
);

   logic w_host_sel;

   assign w_host_sel = i_host_own && !i_busy;

   assign o_data  = w_host_sel ? i_host_data  : i_seq_data;
   assign o_we    = w_host_sel ? i_host_we    : i_seq_we;
   assign o_rdena = w_host_sel ? i_host_rdena : i_seq_rdena;
   assign o_start = w_host_sel ? i_host_start : i_seq_start;
   assign o_reset = w_host_sel ? i_host_reset : i_seq_reset;

endmodule

// File: rtl/ld_i2c_mon_seq.sv
// Periodic laser-driver register poller feeding DAQ/TRG status registers.
// Define LD_MON_TIMEOUT_EN to add the start-to-done watchdog and ABORT path.
import ld_mon_pkg::*;

module ld_i2c_mon_seq #(
   parameter int unsigned POLL_DIV = 4000000,
   parameter int unsigned N_RD     = 4,
   parameter logic [7:0]  REG_ADDR = 8'h00,
   parameter int unsigned TIMEOUT  = 40000
) (
   input  logic        CLK40,
   input  logic        RST_B,
   input  logic        HOST_OWN,
   input  logic [7:0]  HOST_WRT_DATA,
   input  logic        HOST_WE,
   input  logic        HOST_RDENA,
   input  logic        HOST_START,
   input  logic        HOST_RESET,
   input  logic        I2C_CLR_START,
   input  logic [7:0]  I2C_RBK_FIFO_DATA,
   input  logic        DAQ_NACK_FLG,
   input  logic        TRG_NACK_FLG,
   output logic [7:0]  I2C_WRT_FIFO_DATA,
   output logic        I2C_WE,
   output logic        I2C_RDENA,
   output logic        I2C_START,
   output logic        I2C_RESET,
   output logic [31:0] DAQ_STAT,
   output logic [31:0] TRG_STAT,
   output logic        STAT_VLD,
   output logic [1:0]  MON_ERR,
   output logic        MON_BUSY
);

   localparam int CNT_W = $clog2(POLL_DIV);
   localparam bit CFG_OK = (POLL_DIV >= 16) && (N_RD >= 1) &&
                           (N_RD <= 4) && (TIMEOUT >= 1);
   localparam logic [1:0]        RD_LAST = 2'(N_RD - 1);
   localparam logic [BYTE_W-1:0] NB_BYTE = nb_byte(N_RD);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_dev;
   logic              r_pend;
   logic [1:0]        r_rdk;
   logic [1:0]        r_err;
   logic [31:0]       r_shadow;
   logic [31:0]       w_shadow_nxt;
   logic [31:0]       r_daq_stat;
   logic [31:0]       r_trg_stat;
   logic              w_busy;
   logic              w_poll;
   logic              w_nack;
   logic              w_wd_exp;
   logic [BYTE_W-1:0] w_seq_data;
   logic              w_seq_we;
   logic              w_seq_rdena;
   logic              w_seq_start;
   logic              w_seq_reset;

   assign w_busy = (r_state != S_IDLE);
   assign w_poll = CFG_OK && !HOST_OWN &&
                   (r_cnt == CNT_W'(POLL_DIV - 1));
   assign w_nack = r_dev ? TRG_NACK_FLG : DAQ_NACK_FLG;

`ifdef LD_MON_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);

   logic [WD_W-1:0] r_wd;

   assign w_wd_exp = (r_wd == WD_W'(TIMEOUT));

   always_ff @(posedge CLK40 or negedge RST_B) begin
      if (!RST_B) begin
         r_wd <= '0;
      end else if (r_state == S_START || r_state == S_WAIT_DONE) begin
         r_wd <= r_wd + WD_W'(1);
      end else begin
         r_wd <= '0;
      end
   end
`else
   assign w_wd_exp = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_seq_data  = '0;
      w_seq_we    = 1'b0;
      w_seq_rdena = 1'b0;
      w_seq_start = 1'b0;
      w_seq_reset = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_poll) w_state_nxt = S_WR_DEV;
         end
         S_WR_DEV: begin
            w_seq_we    = 1'b1;
            w_seq_data  = r_dev ? DEV_TRG : DEV_DAQ;
            w_state_nxt = S_WR_NB;
         end
         S_WR_NB: begin
            w_seq_we    = 1'b1;
            w_seq_data  = NB_BYTE;
            w_state_nxt = S_WR_ADDR;
         end
         S_WR_ADDR: begin
            w_seq_we    = 1'b1;
            w_seq_data  = REG_ADDR;
            w_state_nxt = S_START;
         end
         S_START, S_WAIT_DONE: begin
            // Done pulse drops START in the same cycle and beats the watchdog.
            w_seq_start = !I2C_CLR_START;
            if (I2C_CLR_START) w_state_nxt = S_GAP;
            else if (w_wd_exp) w_state_nxt = S_ABORT;
            else               w_state_nxt = S_WAIT_DONE;
         end
         S_GAP: begin
            w_state_nxt = S_RD;
         end
         S_RD: begin
            w_seq_rdena = 1'b1;
            if (r_rdk == RD_LAST) w_state_nxt = S_UPDATE;
         end
         S_UPDATE: begin
            w_state_nxt = S_IDLE;
         end
         S_ABORT: begin
            w_seq_reset = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_comb begin
      w_shadow_nxt = r_shadow;
      w_shadow_nxt[{r_rdk, 3'b000} +: BYTE_W] = I2C_RBK_FIFO_DATA;
   end

   always_ff @(posedge CLK40 or negedge RST_B) begin
      if (!RST_B) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_dev      <= 1'b0;
         r_pend     <= 1'b0;
         r_rdk      <= '0;
         r_err      <= '0;
         r_shadow   <= '0;
         r_daq_stat <= '0;
         r_trg_stat <= '0;
      end else begin
         r_state <= w_state_nxt;
         unique case (r_state)
            S_IDLE: begin
               if (HOST_OWN || w_poll) r_cnt <= '0;
               else                    r_cnt <= r_cnt + CNT_W'(1);
            end
            S_WR_DEV: begin
               r_pend   <= 1'b0;
               r_shadow <= '0;
               r_rdk    <= '0;
            end
            S_START, S_WAIT_DONE: begin
               if (w_nack) r_pend <= 1'b1;
            end
            S_RD: begin
               r_shadow <= w_shadow_nxt;
               r_rdk    <= r_rdk + 2'd1;
               // Commit on the last byte so STAT is valid with STAT_VLD.
               if (r_rdk == RD_LAST) begin
                  if (r_pend) begin
                     r_err[r_dev] <= 1'b1;
                  end else begin
                     r_err[r_dev] <= 1'b0;
                     if (r_dev) r_trg_stat <= w_shadow_nxt;
                     else       r_daq_stat <= w_shadow_nxt;
                  end
               end
            end
            S_UPDATE: begin
               r_dev <= ~r_dev;
            end
            S_ABORT: begin
               r_err[r_dev] <= 1'b1;
               r_dev        <= ~r_dev;
            end
            default: begin
            end
         endcase
      end
   end

   assign DAQ_STAT = r_daq_stat;
   assign TRG_STAT = r_trg_stat;
   assign STAT_VLD = (r_state == S_UPDATE) && !r_pend;
   assign MON_ERR  = r_err;
   assign MON_BUSY = w_busy;

   ld_mon_host_mux u_mux (
      .i_busy       (w_busy),
      .i_host_own   (HOST_OWN),
      .i_host_data  (HOST_WRT_DATA),
      .i_host_we    (HOST_WE),
      .i_host_rdena (HOST_RDENA),
      .i_host_start (HOST_START),
      .i_host_reset (HOST_RESET),
      .i_seq_data   (w_seq_data),
      .i_seq_we     (w_seq_we),
      .i_seq_rdena  (w_seq_rdena),
      .i_seq_start  (w_seq_start),
      .i_seq_reset  (w_seq_reset),
      .o_data       (I2C_WRT_FIFO_DATA),
      .o_we         (I2C_WE),
      .o_rdena      (I2C_RDENA),
      .o_start      (I2C_START),
      .o_reset      (I2C_RESET)
   );

endmodule

// File: tb/tb_ld_i2c_mon_seq.sv
// Directed scoreboard bench for ld_i2c_mon_seq with a small I2C slave model.
// Watchdog steps run only when LD_MON_TIMEOUT_EN is defined.
module tb_ld_i2c_mon_seq;

   localparam int unsigned POLL_DIV = 16;
   localparam int unsigned N_RD     = 4;
   localparam logic [7:0]  REG_ADDR = 8'h00;
   localparam int unsigned TIMEOUT  = 100;

   logic        CLK40;
   logic        RST_B;
   logic        HOST_OWN;
   logic [7:0]  HOST_WRT_DATA;
   logic        HOST_WE;
   logic        HOST_RDENA;
   logic        HOST_START;
   logic        HOST_RESET;
   logic        I2C_CLR_START;
   logic [7:0]  I2C_RBK_FIFO_DATA;
   logic        DAQ_NACK_FLG;
   logic        TRG_NACK_FLG;
   logic [7:0]  I2C_WRT_FIFO_DATA;
   logic        I2C_WE;
   logic        I2C_RDENA;
   logic        I2C_START;
   logic        I2C_RESET;
   logic [31:0] DAQ_STAT;
   logic [31:0] TRG_STAT;
   logic        STAT_VLD;
   logic [1:0]  MON_ERR;
   logic        MON_BUSY;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  we_q[$];
   logic [31:0] stat_q[$];
   logic [31:0] exp_daq = '0;
   logic [31:0] exp_trg = '0;
   logic [1:0]  exp_err = '0;
   logic        exp_dev = 1'b0;

   logic [7:0] rbk_mem [256];
   logic [7:0] rbk_idx = '0;

   ld_i2c_mon_seq #(
      .POLL_DIV (POLL_DIV),
      .N_RD     (N_RD),
      .REG_ADDR (REG_ADDR),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .CLK40             (CLK40),
      .RST_B             (RST_B),
      .HOST_OWN          (HOST_OWN),
      .HOST_WRT_DATA     (HOST_WRT_DATA),
      .HOST_WE           (HOST_WE),
      .HOST_RDENA        (HOST_RDENA),
      .HOST_START        (HOST_START),
      .HOST_RESET        (HOST_RESET),
      .I2C_CLR_START     (I2C_CLR_START),
      .I2C_RBK_FIFO_DATA (I2C_RBK_FIFO_DATA),
      .DAQ_NACK_FLG      (DAQ_NACK_FLG),
      .TRG_NACK_FLG      (TRG_NACK_FLG),
      .I2C_WRT_FIFO_DATA (I2C_WRT_FIFO_DATA),
      .I2C_WE            (I2C_WE),
      .I2C_RDENA         (I2C_RDENA),
      .I2C_START         (I2C_START),
      .I2C_RESET         (I2C_RESET),
      .DAQ_STAT          (DAQ_STAT),
      .TRG_STAT          (TRG_STAT),
      .STAT_VLD          (STAT_VLD),
      .MON_ERR           (MON_ERR),
      .MON_BUSY          (MON_BUSY)
   );

   initial CLK40 = 1'b0;
   always #5 CLK40 = ~CLK40;

   // First-word fall-through readback FIFO.
   assign I2C_RBK_FIFO_DATA = rbk_mem[rbk_idx];
   always @(posedge CLK40) begin
      if (I2C_RDENA) rbk_idx <= rbk_idx + 8'd1;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic seq_head(output bit ok, input bit chk_idle);
      int  run;
      int  idle;
      bit  seen;
      logic [7:0] e;
      ok   = 1'b0;
      run  = 0;
      idle = 0;
      seen = 1'b0;
      we_q.push_back(exp_dev ? 8'h04 : 8'h02);
      we_q.push_back(8'h48);
      we_q.push_back(REG_ADDR);
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK40);
         if (I2C_WE) begin
            e = (we_q.size() > 0) ? we_q.pop_front() : 8'hxx;
            chk("we_byte", 64'(I2C_WRT_FIFO_DATA), 64'(e));
            run++;
            seen = 1'b1;
         end else if (I2C_START) begin
            ok = 1'b1;
            break;
         end else begin
            run = 0;
            if (!seen) idle++;
         end
      end
      chk("we_run", ok ? 64'(run) : 64'hffff, 64'd3);
      if (chk_idle) chk("poll_gap", 64'(idle), 64'(POLL_DIV - 1));
      if (ok) chk("busy", 64'(MON_BUSY), 64'd1);
   endtask

   task automatic poll(input logic [31:0] val, input bit nack,
                       input bit host_mid, input bit chk_idle);
      bit ok;
      int first;
      int cnt;
      logic [31:0] e;
      logic [31:0] got;
      for (int k = 0; k < 4; k++) rbk_mem[8'(rbk_idx + 8'(k))] = val[8*k +: 8];
      if (!nack) stat_q.push_back(val);
      seq_head(ok, chk_idle);
      if (!ok) return;
      repeat (2) @(negedge CLK40);
      if (nack) begin
         if (exp_dev) TRG_NACK_FLG = 1'b1;
         else         DAQ_NACK_FLG = 1'b1;
      end
      if (host_mid) begin
         HOST_OWN = 1'b1;
         HOST_WE = 1'b1;
         HOST_WRT_DATA = 8'hEE;
         #1 chk("host_blocked", 64'({I2C_WE, I2C_START, MON_BUSY}), 64'b011);
      end
      @(negedge CLK40);
      DAQ_NACK_FLG = 1'b0;
      TRG_NACK_FLG = 1'b0;
      @(negedge CLK40);
      I2C_CLR_START = 1'b1;
      #1 chk("start_drop", 64'(I2C_START), 64'd0);
      first = 0;
      cnt = 0;
      for (int j = 1; j <= 12; j++) begin
         @(negedge CLK40);
         if (j == 1) I2C_CLR_START = 1'b0;
         if (I2C_RDENA) begin
            if (cnt == 0) first = j;
            cnt++;
         end else if (cnt > 0) begin
            break;
         end
      end
      chk("rd_lat", 64'(first), 64'd2);
      chk("rd_cnt", 64'(cnt), 64'(N_RD));
      chk("stat_vld", 64'(STAT_VLD), 64'(!nack));
      if (STAT_VLD && stat_q.size() > 0) begin
         e = stat_q.pop_front();
         got = exp_dev ? TRG_STAT : DAQ_STAT;
         chk("stat", 64'(got), 64'(e));
      end
      if (!nack) begin
         if (exp_dev) exp_trg = val;
         else         exp_daq = val;
         exp_err[exp_dev] = 1'b0;
      end else begin
         exp_err[exp_dev] = 1'b1;
      end
      exp_dev = ~exp_dev;
      @(negedge CLK40);
      chk("stat_pulse", 64'(STAT_VLD), 64'd0);
      chk("daq_stat", 64'(DAQ_STAT), 64'(exp_daq));
      chk("trg_stat", 64'(TRG_STAT), 64'(exp_trg));
      chk("mon_err", 64'(MON_ERR), 64'(exp_err));
      if (host_mid)
         chk("host_pass", 64'({I2C_WE, I2C_WRT_FIFO_DATA}), 64'({1'b1, 8'hEE}));
   endtask

   initial begin
      bit ok;
      int bad;
      int hit;
      bit found;
      RST_B = 1'b0;
      HOST_OWN = 1'b0;
      HOST_WRT_DATA = '0;
      HOST_WE = 1'b0;
      HOST_RDENA = 1'b0;
      HOST_START = 1'b0;
      HOST_RESET = 1'b0;
      I2C_CLR_START = 1'b0;
      DAQ_NACK_FLG = 1'b0;
      TRG_NACK_FLG = 1'b0;
      for (int i = 0; i < 256; i++) rbk_mem[i] = 8'h00;

      repeat (3) @(negedge CLK40);
      chk("rst_outs", 64'({I2C_WRT_FIFO_DATA, I2C_WE, I2C_RDENA, I2C_START,
                           I2C_RESET, STAT_VLD, MON_ERR, MON_BUSY}), 64'd0);
      chk("rst_stat", {DAQ_STAT, TRG_STAT}, 64'd0);
      RST_B = 1'b1;

      poll(32'h44332211, 1'b0, 1'b0, 1'b0);
      poll(32'hDEADBEEF, 1'b0, 1'b0, 1'b1);
      poll(32'h55AA55AA, 1'b1, 1'b0, 1'b1);
      poll(32'h0BADF00D, 1'b0, 1'b1, 1'b1);

      HOST_WE = 1'b0;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLK40);
         if (I2C_WE || MON_BUSY) bad++;
      end
      chk("host_hold", 64'(bad), 64'd0);
      HOST_WRT_DATA = 8'h5A;
      HOST_WE = 1'b1;
      HOST_RDENA = 1'b1;
      HOST_START = 1'b1;
      HOST_RESET = 1'b1;
      #1 chk("host_mux", 64'({I2C_WRT_FIFO_DATA, I2C_WE, I2C_RDENA,
                               I2C_START, I2C_RESET}), 64'({8'h5A, 4'hF}));
      HOST_RDENA = 1'b0;
      HOST_START = 1'b0;
      HOST_RESET = 1'b0;
      #1 chk("host_mux2", 64'({I2C_WE, I2C_RDENA, I2C_START, I2C_RESET}),
             64'b1000);
      @(negedge CLK40);
      HOST_WE = 1'b0;
      HOST_WRT_DATA = '0;
      HOST_OWN = 1'b0;

      poll(32'h12345678, 1'b0, 1'b0, 1'b0);

`ifdef LD_MON_TIMEOUT_EN
      seq_head(ok, 1'b0);
      hit = 0;
      for (int k = 1; k <= 150; k++) begin
         @(negedge CLK40);
         if (I2C_RESET) begin
            hit = k;
            break;
         end
      end
      chk("wd_cycle", 64'(hit), 64'(TIMEOUT + 1));
      exp_err[exp_dev] = 1'b1;
      exp_dev = ~exp_dev;
      @(negedge CLK40);
      chk("wd_pulse", 64'(I2C_RESET), 64'd0);
      chk("wd_err", 64'(MON_ERR), 64'(exp_err));
`endif

      seq_head(ok, 1'b0);
      repeat (2) @(negedge CLK40);
      I2C_CLR_START = 1'b1;
      @(negedge CLK40);
      I2C_CLR_START = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (I2C_RDENA) begin
            found = 1'b1;
            break;
         end
         @(negedge CLK40);
      end
      chk("rst_in_rd", 64'(found), 64'd1);
      #2 RST_B = 1'b0;
      #1 chk("arst_outs", 64'({I2C_WE, I2C_RDENA, I2C_START, I2C_RESET,
                                STAT_VLD, MON_ERR, MON_BUSY}), 64'd0);
      chk("arst_stat", {DAQ_STAT, TRG_STAT}, 64'd0);
      exp_daq = '0;
      exp_trg = '0;
      exp_err = '0;
      exp_dev = 1'b0;
      we_q.delete();
      stat_q.delete();
      @(negedge CLK40);
      RST_B = 1'b1;

      poll(32'hCAFE0001, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
